// File: rtl/pad_pkg.sv
// Shared definitions for the pad input path: debouncer state encoding and default qualify length.
package pad_pkg;

    localparam int unsigned PAD_DEBOUNCE_DEFAULT = 4;
    localparam int unsigned PAD_STATE_W          = 2;

    typedef logic [PAD_STATE_W-1:0] pad_state_t;

    // Bit 1 marks the debounced level, so S_HIGH/S_FALL both report a pressed pad.
    localparam pad_state_t S_LOW  = 2'b00;
    localparam pad_state_t S_RISE = 2'b01;
    localparam pad_state_t S_HIGH = 2'b11;
    localparam pad_state_t S_FALL = 2'b10;

endpackage

// File: rtl/pad_debouncer_if.sv
// Pad-side signal bundle: raw pad level in, debounced level and qualify flag out.
interface pad_debouncer_if;

    logic raw;
    logic check;
    logic busy;

    modport master (
        output raw,
        input  check,
        input  busy
    );

    modport slave (
        input  raw,
        output check,
        output busy
    );

endinterface

// File: rtl/pad_debouncer_sync2.sv
// Two-flop synchroniser for asynchronous pad inputs; both stages clear on reset.
module pad_sync2 (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/pad_debouncer.sv
// Per-pad debouncer: synchronises raw and qualifies each level change for DEBOUNCE_CYCLES cycles.
// Build option PAD_DEBOUNCE_ACTIVE_LOW_EN inverts raw for pull-up pads (pressed = 0).
module pad_debouncer
    import pad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = PAD_DEBOUNCE_DEFAULT,
    parameter int unsigned CNT_W           = 3
) (
    input  logic            CLK,
    input  logic            RST,
    pad_debouncer_if.slave  pad
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 1 || (2 ** CNT_W) <= DEBOUNCE_CYCLES) begin : g_bad_cfg
            $error("pad_debouncer: need 1 <= DEBOUNCE_CYCLES < 2**CNT_W");
        end
    endgenerate

    logic             raw_level;
    logic             sync_q;
    pad_state_t       state_q;
    pad_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             check_q;
    logic             check_d;
    logic             busy_q;
    logic             busy_d;

`ifdef PAD_DEBOUNCE_ACTIVE_LOW_EN
    assign raw_level = ~pad.raw;
`else
    assign raw_level = pad.raw;
`endif

    pad_sync2 u_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (raw_level),
        .q   (sync_q)
    );

    // Next-state: a new level must hold for DEBOUNCE_CYCLES cycles; any reversal returns to the old level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_LOW: begin
                if (sync_q) begin
                    state_d = S_RISE;
                    cnt_d   = '0;
                end
            end
            S_RISE: begin
                if (!sync_q) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (!sync_q) begin
                    state_d = S_FALL;
                    cnt_d   = '0;
                end
            end
            S_FALL: begin
                if (sync_q) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase

        check_d = (state_d == S_HIGH) || (state_d == S_FALL);
        busy_d  = (state_d == S_RISE) || (state_d == S_FALL);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            check_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            check_q <= check_d;
            busy_q  <= busy_d;
        end
    end

    assign pad.check = check_q;
    assign pad.busy  = busy_q;

endmodule

// File: tb/tb_pad_debouncer.sv
// Self-checking bench for pad_debouncer; stimulus is written in "pressed" terms so it covers
// both the default build and PAD_DEBOUNCE_ACTIVE_LOW_EN.
`timescale 1ns/1ps
module tb_pad_debouncer;
    import pad_pkg::*;

    localparam int unsigned DC = PAD_DEBOUNCE_DEFAULT;
`ifdef PAD_DEBOUNCE_ACTIVE_LOW_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    typedef struct {
        string      tag;
        logic       rst;
        logic       pressed;
        logic [1:0] exp;        // {check, busy} after the edge that consumes this vector
    } vec_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    pad_debouncer_if pad ();

    pad_debouncer #(
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (3)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .pad (pad)
    );

    always #5 CLK = ~CLK;

    vec_t       vecs[$];
    logic [1:0] sb[$];
    int         passed = 0;
    int         total  = 0;

    function automatic void add(string tag, logic rst, logic p, int n, logic [1:0] e);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.tag = tag; v.rst = rst; v.pressed = p; v.exp = e;
            vecs.push_back(v);
        end
    endfunction

    // Press held from S_LOW: two synchroniser edges, DC qualify cycles, then check high.
    function automatic void seg_rise(string tag, int hold);
        add(tag, 1'b0, 1'b1, 2, 2'b00);
        add(tag, 1'b0, 1'b1, DC, 2'b01);
        add(tag, 1'b0, 1'b1, hold - 2 - DC, 2'b10);
    endfunction

    function automatic void seg_fall(string tag, int hold);
        add(tag, 1'b0, 1'b0, 2, 2'b10);
        add(tag, 1'b0, 1'b0, DC, 2'b11);
        add(tag, 1'b0, 1'b0, hold - 2 - DC, 2'b00);
    endfunction

    task automatic step(input vec_t v);
        logic [1:0] got;
        logic [1:0] e;
        @(negedge CLK);
        RST     = v.rst;
        pad.raw = v.pressed ^ INV;
        sb.push_back(v.exp);
        @(posedge CLK);
        #1;
        got = {pad.check, pad.busy};
        e   = sb.pop_front();
        total++;
        if (got === e) passed++;
        else $display("FAIL %s @%0t: {check,busy}=%b expected %b", v.tag, $time, got, e);
    endtask

    initial begin
        int cycles;

        RST     = 1'b1;
        pad.raw = INV;

        // Reset held with the pad pressed, then qualify after release of reset.
        add("reset_hold", 1'b1, 1'b1, 3, 2'b00);
        seg_rise("reset_release", 14);
        seg_fall("release", 20);
        seg_rise("press", 20);
        seg_fall("release2", 20);

        // Three-cycle glitch: busy for three cycles, check never moves.
        add("glitch", 1'b0, 1'b1, 2, 2'b00);
        add("glitch", 1'b0, 1'b1, 1, 2'b01);
        add("glitch", 1'b0, 1'b0, 2, 2'b01);
        add("glitch", 1'b0, 1'b0, 8, 2'b00);

        // Release bounce 0,1,0,1 then stable 0.
        seg_rise("pre_bounce", 14);
        add("bounce", 1'b0, 1'b0, 1, 2'b10);
        add("bounce", 1'b0, 1'b1, 1, 2'b10);
        add("bounce", 1'b0, 1'b0, 1, 2'b11);
        add("bounce", 1'b0, 1'b1, 1, 2'b10);
        add("bounce", 1'b0, 1'b0, 1, 2'b11);
        add("bounce", 1'b0, 1'b0, 1, 2'b10);
        add("bounce", 1'b0, 1'b0, DC, 2'b11);
        add("bounce", 1'b0, 1'b0, 8, 2'b00);

        // Reset while qualifying (cnt == 2), pad still held: must requalify from scratch.
        add("mid_qualify", 1'b0, 1'b1, 2, 2'b00);
        add("mid_qualify", 1'b0, 1'b1, 3, 2'b01);
        add("mid_reset",   1'b1, 1'b1, 1, 2'b00);
        seg_rise("requalify", 14);
        seg_fall("final_release", 14);

        foreach (vecs[i]) step(vecs[i]);

        // Bounded wait: edges from driving a press to check rising (sync1, sync2, DC qualify, S_HIGH).
        @(negedge CLK);
        pad.raw = 1'b1 ^ INV;
        cycles  = 0;
        while (pad.check !== 1'b1 && cycles < 30) begin
            @(posedge CLK);
            #1;
            cycles++;
        end
        total++;
        if (cycles == int'(DC) + 3) passed++;
        else $display("FAIL press_latency: %0d edges expected %0d", cycles, DC + 3);

        // Reset from S_HIGH with the pad held forces check low on the next edge.
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        total++;
        if ({pad.check, pad.busy} === 2'b00) passed++;
        else $display("FAIL reset_from_high: {check,busy}=%b expected 00", {pad.check, pad.busy});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
